// File: rtl/adbg_burst_pkg.sv
// Shared types and constants for the debug-unit Wishbone burst controller.
// The optional CRC datapath is enabled by defining ADBG_BURST_CRC_EN.
package adbg_burst_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    PUSH  = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [3:0] WS_BYTE = 4'd1;
  localparam logic [3:0] WS_HALF = 4'd2;
  localparam logic [3:0] WS_WORD = 4'd4;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Any size code other than byte/half advances the address by a full word.
  function automatic logic [2:0] addr_step(input logic [3:0] ws);
    case (ws)
      WS_BYTE: addr_step = 3'd1;
      WS_HALF: addr_step = 3'd2;
      default: addr_step = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/adbg_crc32.sv
// Single-cycle reflected CRC-32 update over one DATA_WIDTH-bit word, LSB first.
// Only instantiated when ADBG_BURST_CRC_EN is defined.
module adbg_crc32
  import adbg_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           crc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [31:0]           crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data_i[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/adbg_wb_burst_ctrl.sv
// Burst sequencer between the debug command stream and the bus interface unit.
// Define ADBG_BURST_CRC_EN to compute a running CRC-32 over the burst data.
module adbg_wb_burst_ctrl
  import adbg_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  biu_clk,
  input  logic                  biu_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_word_size,
  input  logic [15:0]           cmd_count,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err_flag,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [31:0]           crc_o,
  output logic                  biu_strb,
  output logic                  biu_rw,
  output logic [ADDR_WIDTH-1:0] biu_addr,
  output logic [DATA_WIDTH-1:0] biu_di,
  output logic [3:0]            biu_word_size,
  input  logic                  biu_rdy,
  input  logic [DATA_WIDTH-1:0] biu_do,
  input  logic                  biu_err
);

  state_e                state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            size_q, size_d;
  logic [15:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] di_q, di_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_flag_q, err_flag_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  abort_pend_q, abort_pend_d;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign addr_next = addr_q + ADDR_WIDTH'(addr_step(size_q));

  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    size_d       = size_q;
    count_d      = count_q;
    di_d         = di_q;
    rd_data_d    = rd_data_q;
    err_flag_d   = err_flag_q;
    err_addr_d   = err_addr_q;
    abort_pend_d = abort_pend_q;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    biu_strb     = 1'b0;
    rd_valid     = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rw_d         = cmd_rw;
          addr_d       = cmd_addr;
          size_d       = cmd_word_size;
          count_d      = cmd_count;
          err_flag_d   = 1'b0;
          err_addr_d   = '0;
          abort_pend_d = 1'b0;
          if (cmd_count == 16'd0) state_d = DONE;
          else                    state_d = cmd_rw ? ISSUE : FETCH;
        end
      end
      FETCH: begin
        // Abort wins over a same-cycle data word so nothing is consumed.
        if (abort) begin
          state_d = DONE;
        end else begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            di_d    = wr_data;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        biu_strb = 1'b1;
        if (biu_rdy) begin
          abort_pend_d = abort;
          state_d      = WAIT;
        end else if (abort) begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (biu_rdy) begin
          addr_d  = addr_next;
          count_d = count_q - 16'd1;
          if (biu_err) begin
            err_flag_d = 1'b1;
            if (!err_flag_q) err_addr_d = addr_q;
          end
          if (abort || abort_pend_q) begin
            if (rw_q) rd_data_d = biu_do;
            state_d = DONE;
          end else if (rw_q) begin
            rd_data_d = biu_do;
            state_d   = PUSH;
          end else begin
            state_d = (count_q == 16'd1) ? DONE : FETCH;
          end
        end
      end
      PUSH: begin
        // The count was already decremented when this word completed.
        rd_valid = 1'b1;
        if (rd_ready) state_d = (abort || count_q == 16'd0) ? DONE : ISSUE;
        else if (abort) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge biu_clk) begin
    if (!biu_rst_n) begin
      state_q      <= IDLE;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= 4'd0;
      count_q      <= 16'd0;
      di_q         <= '0;
      rd_data_q    <= '0;
      err_flag_q   <= 1'b0;
      err_addr_q   <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      count_q      <= count_d;
      di_q         <= di_d;
      rd_data_q    <= rd_data_d;
      err_flag_q   <= err_flag_d;
      err_addr_q   <= err_addr_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign biu_rw        = rw_q;
  assign biu_addr      = addr_q;
  assign biu_di        = di_q;
  assign biu_word_size = size_q;
  assign rd_data       = rd_data_q;
  assign err_flag      = err_flag_q;
  assign err_addr      = err_addr_q;

`ifdef ADBG_BURST_CRC_EN
  logic [31:0]           crc_q, crc_d, crc_next;
  logic [DATA_WIDTH-1:0] crc_data;

  // A word counts once: on write-stream acceptance or read-stream delivery.
  assign crc_data = (state_q == FETCH) ? wr_data : rd_data_q;

  adbg_crc32 #(.DATA_WIDTH(DATA_WIDTH)) u_crc (
    .crc_i  (crc_q),
    .data_i (crc_data),
    .crc_o  (crc_next)
  );

  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE && cmd_valid)                    crc_d = CRC_INIT;
    else if (state_q == FETCH && wr_ready && wr_valid)   crc_d = crc_next;
    else if (state_q == PUSH && rd_ready)                crc_d = crc_next;
  end

  always_ff @(posedge biu_clk) begin
    if (!biu_rst_n) crc_q <= CRC_INIT;
    else            crc_q <= crc_d;
  end

  assign crc_o = crc_q;
`else
  assign crc_o = CRC_INIT;
`endif

endmodule

// File: tb/tb_adbg_wb_burst_ctrl.sv
// Self-checking bench for adbg_wb_burst_ctrl: directed burst table, randomized
// bursts against a transaction-level model, plus reset-in-PUSH sequence.
module tb_adbg_wb_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_word_size;
  logic [15:0] cmd_count;
  logic        abort;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic        done, err_flag;
  logic [31:0] err_addr, crc_o;
  logic        biu_strb, biu_rw, biu_rdy, biu_err;
  logic [31:0] biu_addr, biu_di, biu_do;
  logic [3:0]  biu_word_size;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adbg_wb_burst_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .biu_clk(clk), .biu_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_word_size(cmd_word_size), .cmd_count(cmd_count),
    .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err_flag(err_flag), .err_addr(err_addr), .crc_o(crc_o),
    .biu_strb(biu_strb), .biu_rw(biu_rw), .biu_addr(biu_addr), .biu_di(biu_di),
    .biu_word_size(biu_word_size),
    .biu_rdy(biu_rdy), .biu_do(biu_do), .biu_err(biu_err)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [3:0]  ws;
    int          count;
    logic [15:0] errmask;
    int          stall;
    int          abort_mode;   // 0 none, 1 in WAIT, 2 in PUSH, 3 in FETCH
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_err_addr;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r = c;
    for (int i = 0; i < 32; i++) begin
      logic fb = r[0] ^ w[i];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic int step_of(input logic [3:0] ws);
    if (ws == 4'd1) return 1;
    if (ws == 4'd2) return 2;
    return 4;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_word_size = 0; cmd_count = 0;
    abort = 0; wr_data = 0; wr_valid = 0; rd_ready = 0;
    biu_rdy = 0; biu_do = 0; biu_err = 0;
  endtask

  task automatic run_burst(input vec_t v, input bit use_tab);
    logic [31:0] acc_addr[$], acc_di[$], sent_wr[$], got_rd[$], ret_q[$];
    logic        acc_rw[$];
    logic [3:0]  acc_ws[$];
    logic [31:0] ref_rd, a, ea, exp_crc;
    logic        ef;
    int ndone = 0, bphase = 0, dly = 0, ncompl = 0, hold = 0, viol = 0, post = -1;
    int exp_acc, exp_wr, exp_rd, inc;
    bit aborted = 0;

    exp_acc = (v.abort_mode == 0) ? v.count : ((v.abort_mode == 3) ? 0 : 1);
    exp_wr  = v.rw ? 0 : exp_acc;
    exp_rd  = (v.rw && v.abort_mode == 0) ? v.count : 0;
    inc     = step_of(v.ws);

    for (int it = 0; it < 3000 && post != 0; it++) begin
      @(negedge clk);
      if (it == 0) begin
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_rw = v.rw; cmd_addr = v.addr;
        cmd_word_size = v.ws; cmd_count = 16'(v.count);
      end else begin
        cmd_valid = 0;
      end
      if (done) ndone++;

      abort = 0;
      if (!aborted && it > 0) begin
        if ((v.abort_mode == 1 && bphase == 1) || (v.abort_mode == 2 && rd_valid) ||
            (v.abort_mode == 3 && it == 1)) begin
          abort = 1; aborted = 1;
        end
      end

      wr_valid = (v.abort_mode == 3 && it == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_data  = $urandom;

      rd_ready = 0;
      if (rd_valid) begin
        if (hold == 0) ref_rd = rd_data;
        else check("rd_data_stable", rd_data, ref_rd);
        hold++;
        rd_ready = (hold > v.stall) && !abort;
      end

      biu_rdy = 0; biu_err = 0; biu_do = $urandom;
      if (bphase == 1 && biu_strb) viol++;
      if (bphase == 0) begin
        if (biu_strb && $urandom_range(0, 1) == 1) begin
          biu_rdy = 1;
          acc_addr.push_back(biu_addr); acc_rw.push_back(biu_rw);
          acc_di.push_back(biu_di);     acc_ws.push_back(biu_word_size);
          bphase = 1; dly = $urandom_range(0, 3);
        end
      end else if (dly == 0) begin
        biu_rdy = 1;
        biu_err = v.errmask[ncompl[3:0]];
        if (v.rw) ret_q.push_back(biu_do);
        ncompl++; bphase = 0;
      end else begin
        dly--;
      end

      #1;
      if (wr_ready && wr_valid) sent_wr.push_back(wr_data);
      if (rd_valid && rd_ready) begin got_rd.push_back(rd_data); hold = 0; end
      if (ndone > 0 && post < 0) post = 3;
      else if (post > 0) post--;
    end
    check("burst_timeout", post == 0, 1);
    @(negedge clk);
    idle_inputs();

    check("done_pulses", ndone, 1);
    check("access_count", acc_addr.size(), exp_acc);
    check("strb_while_outstanding", viol, 0);
    check("wr_words_taken", sent_wr.size(), exp_wr);
    check("rd_words_delivered", got_rd.size(), exp_rd);
    for (int k = 0; k < acc_addr.size() && k < exp_acc; k++) begin
      a = v.addr + 32'(k * inc);
      check("biu_addr", acc_addr[k], a);
      check("biu_rw", acc_rw[k], v.rw);
      check("biu_word_size", acc_ws[k], v.ws);
      if (!v.rw && k < sent_wr.size()) check("biu_di", acc_di[k], sent_wr[k]);
    end
    for (int k = 0; k < got_rd.size() && k < ret_q.size(); k++)
      check("rd_data", got_rd[k], ret_q[k]);

    ef = 0; ea = 0;
    for (int k = 0; k < exp_acc; k++)
      if (v.errmask[k] && !ef) begin ef = 1; ea = v.addr + 32'(k * inc); end
    check("err_flag", err_flag, ef);
    check("err_addr", err_addr, ea);
    if (use_tab) begin
      check("err_flag_tab", err_flag, v.exp_err);
      check("err_addr_tab", err_addr, v.exp_err_addr);
      if (v.exp_acc > 0 && acc_addr.size() > 0) begin
        check("first_addr_tab", acc_addr[0], v.exp_first);
        check("last_addr_tab", acc_addr[acc_addr.size()-1], v.exp_last);
      end
    end

    exp_crc = 32'hFFFFFFFF;
`ifdef ADBG_BURST_CRC_EN
    if (v.rw) begin
      for (int k = 0; k < exp_rd && k < ret_q.size(); k++) exp_crc = ref_crc(exp_crc, ret_q[k]);
    end else begin
      for (int k = 0; k < sent_wr.size(); k++) exp_crc = ref_crc(exp_crc, sent_wr[k]);
    end
`endif
    check("crc_o", crc_o, exp_crc);
  endtask

  vec_t tab[10];
  vec_t rv;
  logic [3:0] ws_pick[5] = '{4'd1, 4'd2, 4'd4, 4'd3, 4'd0};

  initial begin
    int nd;
    bit seen;
    //           rw    addr          ws  cnt mask    stl ab acc err  eaddr         first         last
    tab[0] = '{1'b0, 32'h100,      4'd4, 3, 16'h0,   0, 0, 3, 1'b0, 32'h0,   32'h100,      32'h108};
    tab[1] = '{1'b1, 32'h3,        4'd1, 2, 16'h0,   5, 0, 2, 1'b0, 32'h0,   32'h3,        32'h4};
    tab[2] = '{1'b0, 32'h200,      4'd4, 4, 16'h2,   0, 0, 4, 1'b1, 32'h204, 32'h200,      32'h20C};
    tab[3] = '{1'b1, 32'hFFFFFFFE, 4'd2, 2, 16'h0,   1, 0, 2, 1'b0, 32'h0,   32'hFFFFFFFE, 32'h0};
    tab[4] = '{1'b1, 32'h10,       4'd3, 3, 16'h5,   1, 0, 3, 1'b1, 32'h10,  32'h10,       32'h18};
    tab[5] = '{1'b0, 32'h7,        4'd2, 0, 16'h0,   0, 0, 0, 1'b0, 32'h0,   32'h0,        32'h0};
    tab[6] = '{1'b0, 32'h40,       4'd4, 3, 16'h0,   0, 1, 1, 1'b0, 32'h0,   32'h40,       32'h40};
    tab[7] = '{1'b1, 32'h80,       4'd1, 3, 16'h0,   9, 2, 1, 1'b0, 32'h0,   32'h80,       32'h80};
    tab[8] = '{1'b0, 32'h90,       4'd4, 2, 16'h0,   0, 3, 0, 1'b0, 32'h0,   32'h0,        32'h0};
    tab[9] = '{1'b0, 32'hFFFFFFFF, 4'd1, 2, 16'h1,   0, 0, 2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};

    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_biu_strb", biu_strb, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_biu_addr", biu_addr, 0);
    check("rst_biu_di", biu_di, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_crc", crc_o, 32'hFFFFFFFF);
    rst_n = 1;

    for (int i = 0; i < 10; i++) run_burst(tab[i], 1'b1);

    for (int i = 0; i < 30; i++) begin
      rv = '{default: '0};
      rv.rw = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      rv.ws = ws_pick[$urandom_range(0, 4)];
      rv.count = $urandom_range(0, 6);
      rv.errmask = 16'($urandom);
      rv.stall = $urandom_range(0, 3);
      run_burst(rv, 1'b0);
    end

    // Reset while a read word is waiting in PUSH.
    @(negedge clk);
    cmd_valid = 1; cmd_rw = 1; cmd_addr = 32'h50; cmd_word_size = 4'd4; cmd_count = 16'd3;
    biu_rdy = 1; biu_do = 32'hDEADBEEF; rd_ready = 0;
    nd = 0; seen = 0;
    for (int it = 0; it < 20 && !seen; it++) begin
      @(negedge clk);
      cmd_valid = 0;
      if (done) nd++;
      if (rd_valid) seen = 1;
    end
    check("push_reached", seen, 1);
    rst_n = 0; biu_rdy = 0;
    @(negedge clk);
    check("rstpush_rd_valid", rd_valid, 0);
    check("rstpush_cmd_ready", cmd_ready, 1);
    check("rstpush_biu_strb", biu_strb, 0);
    check("rstpush_rd_data", rd_data, 0);
    if (done) nd++;
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("rstpush_no_done", nd, 0);
    check("rstpush_idle", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
